// File: rtl/nibble_beat_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_beat_packer_if
// Description : Nibble-stream input and beat-strobe output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_beat_packer_if;
    logic        nib_valid;
    logic [3:0]  nib_data;
    logic        nib_sof;
    logic        nib_eof;
    logic        nib_ready;
    logic [15:0] data_final;
    logic        beat_valid;
    logic        beat_last;
    logic        err;
    logic        err_clr;

    modport master (
        output nib_valid, nib_data, nib_sof, nib_eof, err_clr,
        input  nib_ready, data_final, beat_valid, beat_last, err
    );

    modport slave (
        input  nib_valid, nib_data, nib_sof, nib_eof, err_clr,
        output nib_ready, data_final, beat_valid, beat_last, err
    );
endinterface
`default_nettype wire

// File: rtl/nibble_beat_packer.sv
`default_nettype none
// ============================================================================
// Module      : nibble_beat_packer
// Description : Packs framed 4-bit nibbles little-endian into 16-bit beats.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_beat_packer #(
    parameter int         MAX_BEATS  = 16,
    parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
    input  logic                   clk,
    input  logic                   rst_b,
    nibble_beat_packer_if.slave    bus
);

    localparam int                 C_CNT_W     = $clog2(MAX_BEATS + 1);
    localparam logic [C_CNT_W-1:0] C_MAX_BEATS = C_CNT_W'(MAX_BEATS);
    localparam logic [15:0]        C_PAD_BEAT  = {4{PAD_NIBBLE}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DROP = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_slot, w_slot_nxt;
    logic [C_CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [15:0]          r_acc, w_acc_nxt, w_acc_ins;
    logic [15:0]          r_data_final, w_data_final_nxt;
    logic                 r_beat_valid, w_beat_valid_nxt;
    logic                 r_beat_last, w_beat_last_nxt;
    logic                 r_err, w_err_nxt, w_err_set;
    logic                 w_ready, w_fire;

    assign w_ready   = (r_state != S_GAP);
    assign w_fire    = bus.nib_valid & w_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    // Accumulator starts every beat as all-pad, so unused upper slots come out padded.
    always_comb begin
        w_acc_ins = r_acc;
        w_acc_ins[{r_slot, 2'b00} +: 4] = bus.nib_data;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= S_IDLE;
            r_slot       <= 2'd0;
            r_cnt        <= '0;
            r_acc        <= C_PAD_BEAT;
            r_data_final <= 16'h0000;
            r_beat_valid <= 1'b0;
            r_beat_last  <= 1'b1;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_slot       <= w_slot_nxt;
            r_cnt        <= w_cnt_nxt;
            r_acc        <= w_acc_nxt;
            r_data_final <= w_data_final_nxt;
            r_beat_valid <= w_beat_valid_nxt;
            r_beat_last  <= w_beat_last_nxt;
            r_err        <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_slot_nxt       = r_slot;
        w_cnt_nxt        = r_cnt;
        w_acc_nxt        = r_acc;
        w_data_final_nxt = r_data_final;
        w_beat_valid_nxt = 1'b0;
        w_beat_last_nxt  = r_beat_last;
        w_err_set        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    if (bus.nib_sof) begin
                        if (bus.nib_eof) begin
                            w_data_final_nxt = w_acc_ins;
                            w_beat_valid_nxt = 1'b1;
                            w_beat_last_nxt  = 1'b1;
                            w_state_nxt      = S_GAP;
                        end else begin
                            w_acc_nxt   = w_acc_ins;
                            w_slot_nxt  = 2'd1;
                            w_state_nxt = S_FILL;
                        end
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (w_fire) begin
                    if (bus.nib_sof) begin
                        w_err_set = 1'b1;
                    end
                    if ((r_slot == 2'd3) || bus.nib_eof) begin
                        w_data_final_nxt = w_acc_ins;
                        w_beat_valid_nxt = 1'b1;
                        w_cnt_nxt        = w_cnt_inc;
                        w_acc_nxt        = C_PAD_BEAT;
                        w_slot_nxt       = 2'd0;
                        if (bus.nib_eof) begin
                            w_beat_last_nxt = 1'b1;
                            w_state_nxt     = S_GAP;
                        end else if (w_cnt_inc == C_MAX_BEATS) begin
                            w_beat_last_nxt = 1'b1;
                            w_err_set       = 1'b1;
                            w_state_nxt     = S_DROP;
                        end else begin
                            w_beat_last_nxt = 1'b0;
                        end
                    end else begin
                        w_acc_nxt  = w_acc_ins;
                        w_slot_nxt = r_slot + 2'd1;
                    end
                end
            end
            S_DROP: begin
                if (w_fire && bus.nib_eof) begin
                    w_state_nxt = S_GAP;
                end
            end
            default: begin
                w_slot_nxt  = 2'd0;
                w_cnt_nxt   = '0;
                w_acc_nxt   = C_PAD_BEAT;
                w_state_nxt = S_IDLE;
            end
        endcase

        w_err_nxt = w_err_set ? 1'b1 : (bus.err_clr ? 1'b0 : r_err);
    end

    assign bus.nib_ready  = w_ready;
    assign bus.data_final = r_data_final;
    assign bus.beat_valid = r_beat_valid;
    assign bus.beat_last  = r_beat_last;
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nibble_beat_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_beat_packer
// Description : Scoreboard bench for nibble_beat_packer (MAX_BEATS=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_beat_packer;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
        logic        e;
    } exp_t;

    logic clk;
    logic rst_b;
    int   checks;
    int   failures;
    exp_t q[$];

    nibble_beat_packer_if bus ();

    nibble_beat_packer #(.MAX_BEATS(2), .PAD_NIBBLE(4'h0)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every beat_valid pops one expected beat.
    always @(negedge clk) begin
        if (rst_b && bus.beat_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected: got data=%h last=%b err=%b expected no beat",
                         bus.data_final, bus.beat_last, bus.err);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.data_final !== e.d || bus.beat_last !== e.l || bus.err !== e.e) begin
                    failures++;
                    $display("FAIL beat: got data=%h last=%b err=%b expected data=%h last=%b err=%b",
                             bus.data_final, bus.beat_last, bus.err, e.d, e.l, e.e);
                end
            end
        end
    end

    task automatic expect_beat(input logic [15:0] d, input logic l, input logic e);
        exp_t x;
        x.d = d; x.l = l; x.e = e;
        q.push_back(x);
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [3:0] n, input logic sof, input logic eof);
        int t;
        t = 0;
        while (!bus.nib_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got nib_ready=0 expected 1");
        end
        bus.nib_valid = 1'b1;
        bus.nib_data  = n;
        bus.nib_sof   = sof;
        bus.nib_eof   = eof;
        @(posedge clk); #1;
        bus.nib_valid = 1'b0;
        bus.nib_sof   = 1'b0;
        bus.nib_eof   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic gap_check(input string name);
        chk({name, "_gap_ready"}, {15'd0, bus.nib_ready}, 16'd0);
        @(posedge clk); #1;
        chk({name, "_post_gap_ready"}, {15'd0, bus.nib_ready}, 16'd1);
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        bus.nib_valid = 1'b0;
        bus.nib_data  = 4'h0;
        bus.nib_sof   = 1'b0;
        bus.nib_eof   = 1'b0;
        bus.err_clr   = 1'b0;
        rst_b         = 1'b0;
        #12;
        chk("rst_data",  bus.data_final, 16'h0000);
        chk("rst_valid", {15'd0, bus.beat_valid}, 16'd0);
        chk("rst_last",  {15'd0, bus.beat_last}, 16'd1);
        chk("rst_err",   {15'd0, bus.err}, 16'd0);
        chk("rst_ready", {15'd0, bus.nib_ready}, 16'd1);
        rst_b = 1'b1;
        idle(2);

        // Basic two-beat frame; eof on the MAX_BEATS-th beat is a normal end.
        expect_beat(16'h4321, 1'b0, 1'b0);
        expect_beat(16'h8765, 1'b1, 1'b0);
        send(4'h1, 1, 0); send(4'h2, 0, 0); send(4'h3, 0, 0); send(4'h4, 0, 0);
        send(4'h5, 0, 0); send(4'h6, 0, 0); send(4'h7, 0, 0); send(4'h8, 0, 1);
        gap_check("basic");
        chk("idle_last", {15'd0, bus.beat_last}, 16'd1);
        chk("idle_data_hold", bus.data_final, 16'h8765);

        // Asynchronous reset mid-fill
        send(4'hA, 1, 0); send(4'hB, 0, 0);
        #2 rst_b = 1'b0;
        #1;
        chk("async_rst_data",  bus.data_final, 16'h0000);
        chk("async_rst_last",  {15'd0, bus.beat_last}, 16'd1);
        chk("async_rst_valid", {15'd0, bus.beat_valid}, 16'd0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        idle(4);

        // Short final beat, then two-nibble frame
        expect_beat(16'hDCBA, 1'b1, 1'b0);
        send(4'hA, 1, 0); send(4'hB, 0, 0); send(4'hC, 0, 0); send(4'hD, 0, 1);
        gap_check("short");
        expect_beat(16'h00E9, 1'b1, 1'b0);
        send(4'h9, 1, 0); send(4'hE, 0, 1);
        gap_check("two_nib");

        // Single-nibble frame
        expect_beat(16'h0005, 1'b1, 1'b0);
        send(4'h5, 1, 1);
        gap_check("single");

        // Overrun: 12 nibbles with MAX_BEATS=2
        expect_beat(16'h4321, 1'b0, 1'b0);
        expect_beat(16'h8765, 1'b1, 1'b1);
        send(4'h1, 1, 0); send(4'h2, 0, 0); send(4'h3, 0, 0); send(4'h4, 0, 0);
        send(4'h5, 0, 0); send(4'h6, 0, 0); send(4'h7, 0, 0); send(4'h8, 0, 0);
        chk("drop_ready", {15'd0, bus.nib_ready}, 16'd1);
        send(4'h9, 0, 0); send(4'hA, 0, 0); send(4'hB, 0, 0); send(4'hC, 0, 1);
        gap_check("overrun");
        chk("overrun_err", {15'd0, bus.err}, 16'd1);
        chk("overrun_data_hold", bus.data_final, 16'h8765);
        pulse_clr();
        chk("overrun_err_clr", {15'd0, bus.err}, 16'd0);

        // Nibble without sof in IDLE
        send(4'h7, 0, 0);
        chk("nosof_err", {15'd0, bus.err}, 16'd1);
        chk("nosof_ready", {15'd0, bus.nib_ready}, 16'd1);
        pulse_clr();
        chk("nosof_err_clr", {15'd0, bus.err}, 16'd0);

        // sof inside FILL: flagged, still packed as data
        expect_beat(16'h4321, 1'b0, 1'b1);
        expect_beat(16'h0005, 1'b1, 1'b1);
        send(4'h1, 1, 0); send(4'h2, 1, 0); send(4'h3, 0, 0); send(4'h4, 0, 0);
        send(4'h5, 0, 1);
        gap_check("sof_in_fill");

        // err_clr together with a new violation: set wins
        bus.err_clr = 1'b1;
        send(4'h6, 0, 0);
        bus.err_clr = 1'b0;
        chk("clr_vs_set_err", {15'd0, bus.err}, 16'd1);
        pulse_clr();
        chk("final_err_clr", {15'd0, bus.err}, 16'd0);

        idle(4);
        chk("scoreboard_empty", 16'(q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
